// File: rtl/aposta_entrada.sv
// Bet entry controller: debounced keypad digits into a 5-slot buffer, then emitted to the checker.
// Optional macro APOSTA_DUP_CHECK_EN rejects a digit that is already stored.
module aposta_entrada #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_MAX         = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] tecla,
    input  logic       tecla_valida,
    input  logic       apaga,
    input  logic       confirma,
    input  logic       novo_req,
    output logic [3:0] numero,
    output logic       insere,
    output logic       fim,
    output logic       novo_jogo,
    output logic       erro,
    output logic [2:0] qtd,
    output logic       busy
);

    localparam logic [3:0] DB_TC     = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] DB_SAT    = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] NUM_MAX_L = 4'(NUM_MAX);
    localparam logic [2:0] BET_LEN   = 3'd5;

    // ENTRADA: collecting digits | EMITE: streaming buffer | FIM: end pulse | ESPERA: wait new game
    typedef enum logic [1:0] {ENTRADA, EMITE, FIM, ESPERA} state_t;

    state_t     state_q;
    logic       vld_s1_q, vld_s2_q;
    logic [3:0] tec_s1_q, tec_s2_q;
    logic [3:0] db_cnt_q, db_cnt_d;
    logic       key_acc;
    logic       dup;
    logic [3:0] dig_q [5];
    logic [2:0] qtd_q, idx_q;
    logic [3:0] numero_q;
    logic       insere_q, fim_q, novo_q, erro_q, busy_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_s1_q <= 1'b0;
            vld_s2_q <= 1'b0;
            tec_s1_q <= 4'd0;
            tec_s2_q <= 4'd0;
            db_cnt_q <= 4'd0;
        end else begin
            vld_s1_q <= tecla_valida;
            vld_s2_q <= vld_s1_q;
            tec_s1_q <= tecla;
            tec_s2_q <= tec_s1_q;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Counter saturates one past the terminal count so a held key is accepted only once.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!vld_s2_q)
            db_cnt_d = 4'd0;
        else if (db_cnt_q != DB_SAT)
            db_cnt_d = db_cnt_q + 4'd1;
    end

    assign key_acc = vld_s2_q && (db_cnt_q == DB_TC);

`ifdef APOSTA_DUP_CHECK_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ((3'(i) < qtd_q) && (dig_q[i] == tec_s2_q))
                dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ENTRADA;
            qtd_q    <= 3'd0;
            idx_q    <= 3'd0;
            numero_q <= 4'd0;
            insere_q <= 1'b0;
            fim_q    <= 1'b0;
            novo_q   <= 1'b0;
            erro_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 5; i++)
                dig_q[i] <= 4'd0;
        end else begin
            erro_q <= 1'b0;
            fim_q  <= 1'b0;
            novo_q <= 1'b0;
            case (state_q)
                ENTRADA: begin
                    if (apaga) begin
                        if (qtd_q != 3'd0)
                            qtd_q <= qtd_q - 3'd1;
                    end else if (confirma) begin
                        if (qtd_q == BET_LEN) begin
                            state_q  <= EMITE;
                            busy_q   <= 1'b1;
                            insere_q <= 1'b1;
                            numero_q <= dig_q[0];
                            idx_q    <= 3'd1;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end else if (key_acc) begin
                        if ((tec_s2_q > NUM_MAX_L) || (qtd_q == BET_LEN) || dup) begin
                            erro_q <= 1'b1;
                        end else begin
                            dig_q[qtd_q] <= tec_s2_q;
                            qtd_q        <= qtd_q + 3'd1;
                        end
                    end
                end
                EMITE: begin
                    if (idx_q == BET_LEN) begin
                        state_q  <= FIM;
                        insere_q <= 1'b0;
                        numero_q <= 4'd0;
                        fim_q    <= 1'b1;
                    end else begin
                        numero_q <= dig_q[idx_q];
                        idx_q    <= idx_q + 3'd1;
                    end
                end
                FIM: begin
                    state_q <= ESPERA;
                end
                ESPERA: begin
                    if (novo_req) begin
                        state_q <= ENTRADA;
                        novo_q  <= 1'b1;
                        qtd_q   <= 3'd0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ENTRADA;
                end
            endcase
        end
    end

    assign numero    = numero_q;
    assign insere    = insere_q;
    assign fim       = fim_q;
    assign novo_jogo = novo_q;
    assign erro      = erro_q;
    assign qtd       = qtd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aposta_entrada.sv
// Self-checking bench for aposta_entrada: scoreboard of expected emitted digits plus per-scenario tasks.
module tb_aposta_entrada;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] tecla;
    logic       tecla_valida, apaga, confirma, novo_req;
    logic [3:0] numero;
    logic       insere, fim, novo_jogo, erro, busy;
    logic [2:0] qtd;

    int tests = 0;
    int fails = 0;
    int fim_cnt = 0, erro_cnt = 0, nj_cnt = 0;
    int run = 0, last_run = 0;
    logic [3:0] sb [$];

    aposta_entrada dut (
        .clock(clock), .reset(reset), .tecla(tecla), .tecla_valida(tecla_valida),
        .apaga(apaga), .confirma(confirma), .novo_req(novo_req),
        .numero(numero), .insere(insere), .fim(fim), .novo_jogo(novo_jogo),
        .erro(erro), .qtd(qtd), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (insere) begin
            run++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL emit_unexpected: numero=%0d with empty scoreboard", numero);
            end else begin
                logic [3:0] exp_d;
                exp_d = sb.pop_front();
                if (numero !== exp_d) begin
                    fails++;
                    $display("FAIL emit_digit: got %0d expected %0d", numero, exp_d);
                end
            end
        end else begin
            if (run != 0) last_run = run;
            run = 0;
            if (reset && numero !== 4'd0) begin
                tests++;
                fails++;
                $display("FAIL numero_idle: got %0d expected 0", numero);
            end
        end
        if (fim) fim_cnt++;
        if (erro) erro_cnt++;
        if (novo_jogo) nj_cnt++;
    end

    task automatic press_key(input logic [3:0] d, input int hold);
        @(negedge clock);
        tecla = d;
        tecla_valida = 1'b1;
        repeat (hold) @(negedge clock);
        tecla_valida = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic pulse_confirma();
        @(negedge clock); confirma = 1'b1;
        @(negedge clock); confirma = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_apaga();
        @(negedge clock); apaga = 1'b1;
        @(negedge clock); apaga = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_novo();
        @(negedge clock); novo_req = 1'b1;
        @(negedge clock); novo_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic check_qtd(input string name, input logic [2:0] e);
        tests++;
        if (qtd !== e) begin
            fails++;
            $display("FAIL %s: qtd=%0d expected %0d", name, qtd, e);
        end
    endtask

    task automatic check_erro(input string name, input int e);
        tests++;
        if (erro_cnt !== e) begin
            fails++;
            $display("FAIL %s: erro pulses=%0d expected %0d", name, erro_cnt, e);
        end
    endtask

    task automatic check_busy(input string name, input logic e);
        tests++;
        if (busy !== e) begin
            fails++;
            $display("FAIL %s: busy=%0b expected %0b", name, busy, e);
        end
    endtask

    task automatic enter_bet(input logic [3:0] d0, d1, d2, d3, d4);
        press_key(d0, 8);
        press_key(d1, 8);
        press_key(d2, 8);
        press_key(d3, 8);
        press_key(d4, 8);
    endtask

    task automatic emit_and_check(input string name, input logic [3:0] d0, d1, d2, d3, d4);
        int f0;
        f0 = fim_cnt;
        sb.push_back(d0); sb.push_back(d1); sb.push_back(d2);
        sb.push_back(d3); sb.push_back(d4);
        pulse_confirma();
        for (int i = 0; i < 40 && fim_cnt == f0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        tests++;
        if (fim_cnt !== f0 + 1) begin
            fails++;
            $display("FAIL %s_fim: fim cycles=%0d expected 1", name, fim_cnt - f0);
        end
        tests++;
        if (last_run !== 5) begin
            fails++;
            $display("FAIL %s_run: insere run=%0d expected 5", name, last_run);
        end
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL %s_sb: %0d digits not emitted, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tecla = 4'd0; tecla_valida = 1'b0;
        apaga = 1'b0; confirma = 1'b0; novo_req = 1'b0;
        #12;
        tests++;
        if ({numero, insere, fim, novo_jogo, erro, qtd, busy} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {numero, insere, fim, novo_jogo, erro, qtd, busy});
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_qtd("reset_qtd", 3'd0);
    endtask

    task automatic test_main_bet();
        int n0;
        enter_bet(4'd0, 4'd3, 4'd8, 4'd2, 4'd5);
        check_qtd("main_qtd5", 3'd5);
        emit_and_check("main", 4'd0, 4'd3, 4'd8, 4'd2, 4'd5);
        repeat (5) @(negedge clock);
        check_busy("main_busy_espera", 1'b1);
        n0 = nj_cnt;
        pulse_novo();
        tests++;
        if (nj_cnt !== n0 + 1) begin
            fails++;
            $display("FAIL main_novo_jogo: pulses=%0d expected 1", nj_cnt - n0);
        end
        check_qtd("main_qtd_cleared", 3'd0);
        check_busy("main_busy_cleared", 1'b0);
    endtask

    task automatic test_errors();
        int e0;
        e0 = erro_cnt;
        pulse_apaga();
        check_qtd("err_apaga_empty_qtd", 3'd0);
        check_erro("err_apaga_empty_erro", e0);
        press_key(4'd12, 8);
        check_qtd("err_key12_qtd", 3'd0);
        check_erro("err_key12_erro", e0 + 1);
        press_key(4'd1, 8);
        press_key(4'd4, 8);
        press_key(4'd7, 8);
        check_qtd("err_three_digits", 3'd3);
        pulse_confirma();
        check_erro("err_confirma_short", e0 + 2);
        check_busy("err_confirma_stay", 1'b0);
        pulse_apaga();
        check_qtd("err_apaga_dec", 3'd2);
        pulse_apaga();
        pulse_apaga();
        check_qtd("err_cleanup", 3'd0);
    endtask

    task automatic test_dup();
        int e0;
        e0 = erro_cnt;
        press_key(4'd3, 8);
        press_key(4'd3, 8);
`ifdef APOSTA_DUP_CHECK_EN
        check_qtd("dup_qtd", 3'd1);
        check_erro("dup_erro", e0 + 1);
`else
        check_qtd("dup_qtd", 3'd2);
        check_erro("dup_erro", e0);
`endif
        pulse_apaga();
        pulse_apaga();
        check_qtd("dup_cleanup", 3'd0);
    endtask

    task automatic test_debounce();
        int e0;
        e0 = erro_cnt;
        @(negedge clock);
        tecla = 4'd6;
        tecla_valida = 1'b1;
        repeat (2) @(negedge clock);
        tecla_valida = 1'b0;
        @(negedge clock);
        tecla_valida = 1'b1;
        repeat (2) @(negedge clock);
        tecla_valida = 1'b0;
        repeat (6) @(negedge clock);
        check_qtd("db_bounce_rejected", 3'd0);
        check_erro("db_bounce_no_erro", e0);
        press_key(4'd6, 20);
        check_qtd("db_long_hold_once", 3'd1);
    endtask

    task automatic test_apaga_vs_digit();
        int e0;
        e0 = erro_cnt;
        @(negedge clock);
        tecla = 4'd7;
        tecla_valida = 1'b1;
        repeat (5) @(negedge clock);
        apaga = 1'b1;
        @(negedge clock);
        apaga = 1'b0;
        repeat (2) @(negedge clock);
        tecla_valida = 1'b0;
        repeat (5) @(negedge clock);
        check_qtd("apaga_wins_qtd", 3'd0);
        check_erro("apaga_wins_erro", e0);
    endtask

    task automatic test_reset_emite();
        int f0;
        int k;
        enter_bet(4'd1, 4'd2, 4'd4, 4'd6, 4'd8);
        f0 = fim_cnt;
        sb.push_back(4'd1); sb.push_back(4'd2); sb.push_back(4'd4);
        sb.push_back(4'd6); sb.push_back(4'd8);
        @(negedge clock); confirma = 1'b1;
        @(negedge clock); confirma = 1'b0;
        k = 0;
        while (!insere && k < 10) begin
            @(negedge clock);
            k++;
        end
        tests++;
        if (!insere) begin
            fails++;
            $display("FAIL rst_emite_start: insere=%0b expected 1", insere);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        tests++;
        if (insere !== 1'b0 || numero !== 4'd0) begin
            fails++;
            $display("FAIL rst_emite_abort: insere=%0b numero=%0d expected 0 0", insere, numero);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        repeat (10) @(negedge clock);
        check_qtd("rst_emite_qtd", 3'd0);
        check_busy("rst_emite_busy", 1'b0);
        tests++;
        if (fim_cnt !== f0) begin
            fails++;
            $display("FAIL rst_emite_fim: fim cycles=%0d expected 0", fim_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        int e0, n0;
        n0 = nj_cnt;
        pulse_novo();
        tests++;
        if (nj_cnt !== n0) begin
            fails++;
            $display("FAIL b2b_novo_in_entrada: pulses=%0d expected 0", nj_cnt - n0);
        end
        enter_bet(4'd9, 4'd1, 4'd6, 4'd4, 4'd7);
        check_qtd("b2b_qtd5", 3'd5);
        e0 = erro_cnt;
        press_key(4'd2, 8);
        check_qtd("b2b_full_qtd", 3'd5);
        check_erro("b2b_full_erro", e0 + 1);
        emit_and_check("b2b", 4'd9, 4'd1, 4'd6, 4'd4, 4'd7);
        e0 = erro_cnt;
        press_key(4'd3, 8);
        pulse_confirma();
        pulse_apaga();
        check_erro("b2b_espera_ignored", e0);
        check_qtd("b2b_espera_qtd", 3'd5);
        check_busy("b2b_espera_busy", 1'b1);
        n0 = nj_cnt;
        pulse_novo();
        tests++;
        if (nj_cnt !== n0 + 1) begin
            fails++;
            $display("FAIL b2b_novo_jogo: pulses=%0d expected 1", nj_cnt - n0);
        end
        check_qtd("b2b_qtd_cleared", 3'd0);
        check_busy("b2b_busy_cleared", 1'b0);
    endtask

    initial begin
        test_reset();
        test_main_bet();
        test_errors();
        test_dup();
        test_debounce();
        pulse_apaga();
        test_apaga_vs_digit();
        test_reset_emite();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aposta_entrada.md
APOSTA_ENTRADA -- requirements
Module: aposta_entrada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable-high cycles required to accept a key press (range 1..15).
REQ-002 Parameter NUM_MAX, default 9, largest legal bet digit.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-005 tecla  input  4  raw keypad value; stable while tecla_valida is high.
REQ-006 tecla_valida  input  1  raw, bouncy, asynchronous key-pressed level.
REQ-007 apaga  input  1  synchronous single-cycle strobe; removes the last stored digit.
REQ-008 confirma  input  1  synchronous single-cycle strobe; submits the bet.
REQ-009 novo_req  input  1  synchronous single-cycle strobe; requests a new game.
REQ-010 numero  output  4  digit presented to the lottery checker.
REQ-011 insere  output  1  high while numero carries a valid bet digit.
REQ-012 fim  output  1  one-cycle pulse after the last digit.
REQ-013 novo_jogo  output  1  one-cycle pulse that starts a new game downstream.
REQ-014 erro  output  1  one-cycle pulse on any rejected action.
REQ-015 qtd  output  3  digits currently stored (0..5).
REQ-016 busy  output  1  high in any state other than ENTRADA.

Function
REQ-017 tecla_valida and tecla SHALL pass through a 2-flop synchronizer; a press SHALL be accepted in the cycle the synchronized level has been high DEBOUNCE_CYCLES consecutive cycles, once per press; re-arm requires one synchronized-low cycle.
REQ-018 States SHALL be ENTRADA, EMITE, FIM, ESPERA; reset enters ENTRADA.
REQ-019 In ENTRADA, an accepted digit SHALL be stored at index qtd and qtd incremented, unless digit > NUM_MAX, qtd == 5, or it is a duplicate (see REQ-030); each rejection SHALL pulse erro the following cycle, with qtd unchanged.
REQ-020 In ENTRADA, apaga SHALL decrement qtd when qtd > 0 and be ignored silently when qtd == 0.
REQ-021 Simultaneous apaga and accepted digit: apaga wins, digit discarded, no erro.
REQ-022 In ENTRADA, confirma with qtd == 5 SHALL move to EMITE next cycle; with qtd < 5 SHALL pulse erro and stay.
REQ-023 EMITE SHALL drive insere = 1 for exactly 5 consecutive cycles with numero = buf[0]..buf[4] in entry order, then go to FIM.
REQ-024 FIM SHALL last one cycle with fim = 1 and insere = 0, then go to ESPERA.
REQ-025 In ESPERA, novo_req SHALL pulse novo_jogo for one cycle, clear qtd to 0, and return to ENTRADA.
REQ-026 Outside ENTRADA, key presses, apaga and confirma SHALL be ignored without erro; novo_req outside ESPERA SHALL be ignored.
REQ-027 numero SHALL be 0 whenever insere = 0; all outputs SHALL be registered.

Reset
REQ-028 Reset low SHALL force numero=0, insere=0, fim=0, novo_jogo=0, erro=0, qtd=0, busy=0, buffer=0, debounce counter=0, synchronizers=0, state ENTRADA.
REQ-029 Reset during EMITE SHALL abort emission with no fim pulse; after release, the block is in ENTRADA with an empty bet.

Configuration
REQ-030 Macro APOSTA_DUP_CHECK_EN defined: a digit equal to any stored digit is rejected with erro; undefined: duplicates are stored as normal digits and no comparators are built.

Verification
REQ-031 Keys 0,3,8,2,5 (each held 8 cycles), then confirma -> qtd=5; insere high 5 consecutive cycles with numero 0,3,8,2,5; fim high for 1 cycle; busy high until novo_req.
REQ-032 Key 12 -> erro pulse, qtd unchanged; confirma at qtd=3 -> erro, still ENTRADA; apaga at qtd=0 -> no change, no erro.
REQ-033 Keys 3,3 -> with APOSTA_DUP_CHECK_EN: erro, qtd=1; without: qtd=2.
REQ-034 tecla_valida high 2 cycles, low 1, high 2 (DEBOUNCE_CYCLES=4) -> nothing accepted; held high 20 cycles -> exactly one digit accepted.
REQ-035 Reset asserted in 3rd EMITE cycle -> insere=0 immediately; after release qtd=0, no fim.
REQ-036 ESPERA + novo_req -> novo_jogo 1 cycle, qtd=0, busy=0; a second bet of 5 digits emits correctly.
